// File: rtl/odometer_meas_seq_if.sv
// Control/status bundle between the odometer sequencer and its scan-in/scan-out
// neighbours: configuration, async trigger/beat inputs, stress drives and result.
interface odometer_meas_seq_if #(
  parameter int unsigned CNT_W = 12
);
  logic             stress_en;
  logic             ac_mode;
  logic             meas_trig;
  logic             beat;
  logic             stress_on;
  logic             ac_toggle;
  logic             meas_en;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             overflow;
  logic [23:0]      stress_cycles;

  modport master (
    output stress_en, ac_mode, meas_trig, beat,
    input  stress_on, ac_toggle, meas_en, busy, result, result_valid, overflow,
           stress_cycles
  );

  modport slave (
    input  stress_en, ac_mode, meas_trig, beat,
    output stress_on, ac_toggle, meas_en, busy, result, result_valid, overflow,
           stress_cycles
  );
endinterface

// File: rtl/odometer_meas_seq.sv
// Stress/measure sequencer and beat counter for the odometer aging sensor.
// Optional stress-cycle counter built only when ODO_STRESS_CYCLE_CNT_EN is defined.
module odometer_meas_seq #(
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input logic                CLK,
  input logic                RESETB,
  odometer_meas_seq_if.slave bus
);

  localparam int unsigned CYC_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES
                                                                    : WINDOW_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned SC_W    = 24;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STRESS  = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]             state, state_nxt;
  logic [CYC_W-1:0]       cyc_cnt, cyc_nxt;
  logic [CNT_W-1:0]       beat_cnt, beat_cnt_nxt;
  logic                   ovf, ovf_nxt;

  logic [SYNC_STAGES-1:0] trig_sync, beat_sync;
  logic                   trig_d, beat_d;
  logic                   trig_s, beat_s;
  logic                   trig_rise, beat_rise;

  logic                   stress_on, stress_on_nxt;
  logic                   ac_toggle, ac_toggle_nxt;
  logic                   meas_en, meas_en_nxt;
  logic                   busy, busy_nxt;
  logic [CNT_W-1:0]       result, result_nxt;
  logic                   result_valid, result_valid_nxt;
  logic                   overflow, overflow_nxt;

  assign trig_s    = trig_sync[SYNC_STAGES-1];
  assign beat_s    = beat_sync[SYNC_STAGES-1];
  assign trig_rise = trig_s & ~trig_d;
  assign beat_rise = beat_s & ~beat_d;

  // Synchronizers and edge-detect history for the two asynchronous inputs
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      trig_sync <= '0;
      beat_sync <= '0;
      trig_d    <= 1'b0;
      beat_d    <= 1'b0;
    end else begin
      trig_sync <= {trig_sync[SYNC_STAGES-2:0], bus.meas_trig};
      beat_sync <= {beat_sync[SYNC_STAGES-2:0], bus.beat};
      trig_d    <= trig_s;
      beat_d    <= beat_s;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state        <= ST_IDLE;
      cyc_cnt      <= '0;
      beat_cnt     <= '0;
      ovf          <= 1'b0;
      stress_on    <= 1'b0;
      ac_toggle    <= 1'b0;
      meas_en      <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cyc_cnt      <= cyc_nxt;
      beat_cnt     <= beat_cnt_nxt;
      ovf          <= ovf_nxt;
      stress_on    <= stress_on_nxt;
      ac_toggle    <= ac_toggle_nxt;
      meas_en      <= meas_en_nxt;
      busy         <= busy_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      overflow     <= overflow_nxt;
    end
  end

  // Next state, counter updates, and outputs decoded from the next state
  always_comb begin
    state_nxt        = state;
    cyc_nxt          = cyc_cnt;
    beat_cnt_nxt     = beat_cnt;
    ovf_nxt          = ovf;
    stress_on_nxt    = 1'b0;
    ac_toggle_nxt    = 1'b0;
    meas_en_nxt      = 1'b0;
    busy_nxt         = 1'b0;
    result_nxt       = result;
    result_valid_nxt = result_valid;
    overflow_nxt     = overflow;

    case (state)
      ST_IDLE: begin
        if (trig_rise)          state_nxt = ST_SETTLE;
        else if (bus.stress_en) state_nxt = ST_STRESS;
      end
      ST_STRESS: begin
        if (trig_rise)          state_nxt = ST_SETTLE;
        else if (!bus.stress_en) state_nxt = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cyc_cnt == CYC_W'(SETTLE_CYCLES - 1)) begin
          state_nxt = ST_MEASURE;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt   = cyc_cnt + CYC_W'(1);
        end
      end
      ST_MEASURE: begin
        if (beat_rise) begin
          if (beat_cnt == {CNT_W{1'b1}}) ovf_nxt      = 1'b1;
          else                           beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
        if (cyc_cnt == CYC_W'(WINDOW_CYCLES - 1)) begin
          state_nxt = ST_DONE;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt   = cyc_cnt + CYC_W'(1);
        end
      end
      ST_DONE: begin
        // a held-high trigger parks us here, so it can never retrigger
        if (!trig_s) state_nxt = bus.stress_en ? ST_STRESS : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_SETTLE && state != ST_SETTLE) begin
      cyc_nxt          = '0;
      beat_cnt_nxt     = '0;
      ovf_nxt          = 1'b0;
      result_valid_nxt = 1'b0;
      overflow_nxt     = 1'b0;
    end

    // the final window cycle's beat edge is included via beat_cnt_nxt/ovf_nxt
    if (state_nxt == ST_DONE && state == ST_MEASURE) begin
      result_nxt       = beat_cnt_nxt;
      overflow_nxt     = ovf_nxt;
      result_valid_nxt = 1'b1;
    end

    case (state_nxt)
      ST_STRESS: begin
        stress_on_nxt = 1'b1;
        ac_toggle_nxt = bus.ac_mode ? ~ac_toggle : 1'b1;
      end
      ST_SETTLE, ST_MEASURE: begin
        meas_en_nxt = 1'b1;
        busy_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ODO_STRESS_CYCLE_CNT_EN
  logic [SC_W-1:0] stress_cnt;

  // Lifetime stress-cycle counter, saturating, cleared only by reset
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      stress_cnt <= '0;
    end else if (state == ST_STRESS && stress_cnt != {SC_W{1'b1}}) begin
      stress_cnt <= stress_cnt + SC_W'(1);
    end
  end

  assign bus.stress_cycles = stress_cnt;
`else
  assign bus.stress_cycles = '0;
`endif

  assign bus.stress_on    = stress_on;
  assign bus.ac_toggle    = ac_toggle;
  assign bus.meas_en      = meas_en;
  assign bus.busy         = busy;
  assign bus.result       = result;
  assign bus.result_valid = result_valid;
  assign bus.overflow     = overflow;

endmodule

// File: tb/tb_odometer_meas_seq.sv
// Directed bench for odometer_meas_seq: default-window instance plus an 8192-cycle
// window instance for the saturation case.
module tb_odometer_meas_seq;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   beat_per_a;
  int   ph_a;
  bit   beat_b_on;
  int   len;
  int   extra;
  int   sc_on;

  odometer_meas_seq_if #(.CNT_W(12)) ifa ();
  odometer_meas_seq_if #(.CNT_W(12)) ifb ();

  odometer_meas_seq #(
    .CNT_W(12), .SETTLE_CYCLES(16), .WINDOW_CYCLES(1024), .SYNC_STAGES(2)
  ) dut_a (
    .CLK(clk), .RESETB(rst_n), .bus(ifa)
  );

  odometer_meas_seq #(
    .CNT_W(12), .SETTLE_CYCLES(16), .WINDOW_CYCLES(8192), .SYNC_STAGES(2)
  ) dut_b (
    .CLK(clk), .RESETB(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square-wave beat sources, updated away from the active edge
  always @(negedge clk) begin
    if (beat_per_a == 0) begin
      ifa.beat = 1'b0;
      ph_a     = 0;
    end else begin
      ifa.beat = (ph_a < beat_per_a / 2);
      ph_a     = (ph_a + 1) % beat_per_a;
    end
  end

  always @(negedge clk) ifb.beat = beat_b_on ? ~ifb.beat : 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Count busy cycles until busy falls (busy already seen high once); optional trigger glitch
  task automatic wait_done_a(input bit glitch, output int busy_len);
    busy_len = 1;
    for (int k = 0; k < 3000 && ifa.busy; k++) begin
      if (glitch && k == 500) ifa.meas_trig = 1'b0;
      if (glitch && k == 504) ifa.meas_trig = 1'b1;
      @(negedge clk);
      if (ifa.busy) busy_len++;
    end
  endtask

  task automatic wait_done_b(output int busy_len);
    busy_len = 1;
    for (int k = 0; k < 10000 && ifb.busy; k++) begin
      @(negedge clk);
      if (ifb.busy) busy_len++;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
`ifdef ODO_STRESS_CYCLE_CNT_EN
    sc_on = 1;
`else
    sc_on = 0;
`endif
    rst_n         = 1'b0;
    beat_per_a    = 0;
    beat_b_on     = 1'b0;
    ifa.stress_en = 1'b0; ifa.ac_mode = 1'b0; ifa.meas_trig = 1'b0;
    ifb.stress_en = 1'b0; ifb.ac_mode = 1'b0; ifb.meas_trig = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_stress_on", 32'(ifa.stress_on), 32'd0);
    chk("rst_ac_toggle", 32'(ifa.ac_toggle), 32'd0);
    chk("rst_meas_en", 32'(ifa.meas_en), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_result", 32'(ifa.result), 32'd0);
    chk("rst_valid", 32'(ifa.result_valid), 32'd0);
    chk("rst_overflow", 32'(ifa.overflow), 32'd0);
    chk("rst_stress_cycles", 32'(ifa.stress_cycles), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stress drive: AC toggling, then DC, then back to idle
    ifa.stress_en = 1'b1;
    ifa.ac_mode   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ac_toggle_ac", 32'(ifa.ac_toggle), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("stress_on_ac", 32'(ifa.stress_on), 32'd1);
    end
    ifa.ac_mode = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("ac_toggle_dc", 32'(ifa.ac_toggle), 32'd1);
    end
    ifa.stress_en = 1'b0;
    @(negedge clk);
    chk("idle_stress_on", 32'(ifa.stress_on), 32'd0);
    chk("idle_ac_toggle", 32'(ifa.ac_toggle), 32'd0);
    chk("idle_meas_en", 32'(ifa.meas_en), 32'd0);

    // Measurement from STRESS, period-16 beat, trigger glitch mid-window and held through DONE
    ifa.stress_en = 1'b1;
    ifa.ac_mode   = 1'b1;
    repeat (5) @(negedge clk);
    beat_per_a    = 16;
    ifa.meas_trig = 1'b1;
    @(negedge clk); chk("trig_lat_1", 32'(ifa.busy), 32'd0);
    @(negedge clk); chk("trig_lat_2", 32'(ifa.busy), 32'd0);
    @(negedge clk); chk("trig_lat_3", 32'(ifa.busy), 32'd1);
    chk("settle_meas_en", 32'(ifa.meas_en), 32'd1);
    chk("settle_stress_on", 32'(ifa.stress_on), 32'd0);
    wait_done_a(1'b1, len);
    chk("busy_len_16", 32'(len), 32'd1040);
    chk("result_16", 32'(ifa.result), 32'd64);
    chk("valid_16", 32'(ifa.result_valid), 32'd1);
    chk("ovf_16", 32'(ifa.overflow), 32'd0);
    chk("done_meas_en", 32'(ifa.meas_en), 32'd0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.busy || ifa.stress_on) extra++;
    end
    chk("held_trig_no_retrig", 32'(extra), 32'd0);
    ifa.meas_trig = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_hold_sync", 32'(ifa.stress_on), 32'd0);
    @(negedge clk);
    chk("stress_resume", 32'(ifa.stress_on), 32'd1);
    chk("result_stable", 32'(ifa.result), 32'd64);
    beat_per_a = 0;

    // Async reset 500 cycles into the measurement
    ifa.meas_trig = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 32'(ifa.busy), 32'd1);
    repeat (500) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(ifa.busy), 32'd0);
    chk("arst_meas_en", 32'(ifa.meas_en), 32'd0);
    chk("arst_stress_on", 32'(ifa.stress_on), 32'd0);
    chk("arst_ac_toggle", 32'(ifa.ac_toggle), 32'd0);
    chk("arst_result", 32'(ifa.result), 32'd0);
    chk("arst_valid", 32'(ifa.result_valid), 32'd0);
    chk("arst_overflow", 32'(ifa.overflow), 32'd0);
    ifa.stress_en = 1'b0;
    ifa.meas_trig = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(ifa.stress_on | ifa.busy | ifa.meas_en), 32'd0);
    beat_per_a    = 8;
    ifa.meas_trig = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(ifa.busy), 32'd1);
    wait_done_a(1'b0, len);
    chk("busy_len_8", 32'(len), 32'd1040);
    chk("result_8", 32'(ifa.result), 32'd128);
    chk("valid_8", 32'(ifa.result_valid), 32'd1);
    chk("ovf_8", 32'(ifa.overflow), 32'd0);
    ifa.meas_trig = 1'b0;
    beat_per_a    = 0;
    repeat (4) @(negedge clk);
    chk("back_to_idle", 32'(ifa.stress_on | ifa.ac_toggle), 32'd0);

    // Stress-cycle counter: 100 cycles, a measurement, 50 more
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("sc_cleared", 32'(ifa.stress_cycles), 32'd0);
    ifa.stress_en = 1'b1;
    repeat (100) @(negedge clk);
    ifa.stress_en = 1'b0;
    @(negedge clk);
    chk("sc_100", 32'(ifa.stress_cycles), (sc_on != 0) ? 32'd100 : 32'd0);
    ifa.meas_trig = 1'b1;
    repeat (3) @(negedge clk);
    wait_done_a(1'b0, len);
    chk("sc_meas_len", 32'(len), 32'd1040);
    ifa.meas_trig = 1'b0;
    repeat (4) @(negedge clk);
    chk("sc_after_meas", 32'(ifa.stress_cycles), (sc_on != 0) ? 32'd100 : 32'd0);
    ifa.stress_en = 1'b1;
    repeat (50) @(negedge clk);
    ifa.stress_en = 1'b0;
    @(negedge clk);
    chk("sc_150", 32'(ifa.stress_cycles), (sc_on != 0) ? 32'd150 : 32'd0);

    // Long window, period-2 beat saturates the counter; then a static-beat rerun
    beat_b_on     = 1'b1;
    ifb.meas_trig = 1'b1;
    repeat (3) @(negedge clk);
    chk("b_busy", 32'(ifb.busy), 32'd1);
    wait_done_b(len);
    chk("b_busy_len", 32'(len), 32'd8208);
    chk("b_result_sat", 32'(ifb.result), 32'd4095);
    chk("b_overflow", 32'(ifb.overflow), 32'd1);
    chk("b_valid", 32'(ifb.result_valid), 32'd1);
    ifb.meas_trig = 1'b0;
    beat_b_on     = 1'b0;
    repeat (4) @(negedge clk);
    ifb.meas_trig = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_valid_before_settle", 32'(ifb.result_valid), 32'd1);
    @(negedge clk);
    chk("b_valid_drop", 32'(ifb.result_valid), 32'd0);
    chk("b_ovf_drop", 32'(ifb.overflow), 32'd0);
    wait_done_b(len);
    chk("b_result_zero", 32'(ifb.result), 32'd0);
    chk("b_ovf_zero", 32'(ifb.overflow), 32'd0);
    chk("b_valid2", 32'(ifb.result_valid), 32'd1);
    ifb.meas_trig = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
